// File: rtl/fns_cac_encoder_seq_if.sv
// Handshake bundle between the binary data source, the FNS encoder and the bus driver.
interface fns_cac_encoder_seq_if #(
    parameter int unsigned IN_W   = 15,
    parameter int unsigned CODE_W = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   datain;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] codeout;
    logic              out_err;

    // Source/consumer side
    modport master (
        output in_valid, datain, out_ready,
        input  in_ready, out_valid, codeout, out_err
    );

    // Encoder side
    modport slave (
        input  in_valid, datain, out_ready,
        output in_ready, out_valid, codeout, out_err
    );
endinterface

// File: rtl/fns_cac_encoder_seq.sv
// Sequential Fibonacci-numeral-system crosstalk-avoidance encoder.
// Resolves BPC code bits per cycle from the MSB down with a greedy/tie rule,
// flags inputs at or above f(CODE_W+2) and returns a zero codeword for them.
module fns_cac_encoder_seq #(
    parameter int unsigned CODE_W  = 20,
    parameter int unsigned IN_W    = 15,
    parameter int unsigned BPC     = 1,
    parameter bit          TIE_MSB = 1'b0
) (
    input logic                  clock,
    input logic                  reset,
    fns_cac_encoder_seq_if.slave bus
);
    // Weights need one spare bit so f(CODE_W+2) is representable next to an IN_W remainder.
    localparam int unsigned WW = IN_W + 1;
    localparam int unsigned TW = $clog2(CODE_W + 2);
    localparam logic [TW-1:0] TOP_IDX = TW'(CODE_W - 1);
    localparam logic [TW-1:0] BPC_T   = TW'(BPC);

    // Entry n holds f(n+1): entries 0..CODE_W-1 are bit weights, CODE_W+1 is the range limit.
    typedef logic [CODE_W+1:0][WW-1:0] weight_tab_t;

    function automatic weight_tab_t gen_weights();
        weight_tab_t     t;
        logic [WW-1:0]   a;
        logic [WW-1:0]   b;
        logic [WW-1:0]   s;
        t = '0;
        a = WW'(1);
        b = WW'(1);
        for (int unsigned n = 0; n <= CODE_W + 1; n++) begin
            t = t | (weight_tab_t'(a) << (n * WW));
            s = a + b;
            a = b;
            b = s;
        end
        return t;
    endfunction

    localparam weight_tab_t   WEIGHTS = gen_weights();
    localparam logic [WW-1:0] LIMIT   = WEIGHTS[TW'(CODE_W + 1)];

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     r_q, r_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                last_q, last_d;
    logic [TW-1:0]       idx_q, idx_d;
    logic                err_q, err_d;
    logic [CODE_W-1:0]   codeout_q, codeout_d;
    logic                out_err_q, out_err_d;
    logic                out_valid_q, out_valid_d;

    logic [IN_W-1:0]     step_r;
    logic [CODE_W-1:0]   step_code;
    logic                step_last;
    logic                step_fin;
    logic [TW-1:0]       k;
    logic [WW-1:0]       wk;
    logic [WW-1:0]       wk1;
    logic                b;
    logic                load_c;

    // One ENC step: decide up to BPC bits from idx_q downward; bit 0 rides with bit 1.
    always_comb begin
        step_r    = r_q;
        step_code = code_q;
        step_last = last_q;
        step_fin  = 1'b0;
        k         = '0;
        wk        = '0;
        wk1       = '0;
        b         = 1'b0;
        for (int unsigned j = 0; j < BPC; j++) begin
            if (TW'(j) < idx_q) begin
                k   = idx_q - TW'(j);
                wk  = WEIGHTS[k];
                wk1 = WEIGHTS[k + TW'(1)];
                if (WW'(step_r) < wk) begin
                    b = 1'b0;
                end else if (WW'(step_r) >= wk1) begin
                    b = 1'b1;
                end else begin
                    b = step_last;
                end
                if (b) begin
                    step_r = step_r - IN_W'(wk);
                end
                step_code = step_code | (CODE_W'(b) << k);
                step_last = b;
                if (k == TW'(1)) begin
                    step_code = step_code | CODE_W'(step_r[0]);
                    step_fin  = 1'b1;
                end
            end
        end
    end

    // Next-state and datapath/output updates for the IDLE/ENC/DONE controller.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        code_d      = code_q;
        last_d      = last_q;
        idx_d       = idx_q;
        err_d       = err_q;
        codeout_d   = codeout_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        load_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load_c = 1'b1;
                end
            end
            ENC: begin
                r_d    = step_r;
                code_d = step_code;
                last_d = step_last;
                idx_d  = (idx_q > BPC_T) ? idx_q - BPC_T : '0;
                if (step_fin) begin
                    codeout_d   = err_q ? '0 : step_code;
                    out_err_d   = err_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_c) begin
            r_d     = bus.datain;
            code_d  = '0;
            last_d  = TIE_MSB;
            idx_d   = TOP_IDX;
            err_d   = (WW'(bus.datain) >= LIMIT);
            state_d = ENC;
        end
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            code_q      <= '0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            codeout_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            code_q      <= code_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            codeout_q   <= codeout_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready looks through to out_ready in DONE so back-to-back words see no bubble.
    assign bus.in_ready  = !reset && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign bus.out_valid = out_valid_q;
    assign bus.codeout   = codeout_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_fns_cac_encoder_seq.sv
// Directed bench for the FNS encoder: default, TIE_MSB=1 and BPC=4 instances.
module tb_fns_cac_encoder_seq;
    logic clock = 1'b0;
    logic reset;

    logic        in_valid, out_ready;
    logic [14:0] datain;
    logic        b_valid, b_ready;
    logic [14:0] b_data;

    int errors = 0;
    int checks = 0;

    fns_cac_encoder_seq_if #(.IN_W(15), .CODE_W(20)) m_if ();
    fns_cac_encoder_seq_if #(.IN_W(15), .CODE_W(20)) t_if ();
    fns_cac_encoder_seq_if #(.IN_W(15), .CODE_W(20)) b_if ();

    assign m_if.in_valid  = in_valid;
    assign m_if.datain    = datain;
    assign m_if.out_ready = out_ready;
    assign t_if.in_valid  = in_valid;
    assign t_if.datain    = datain;
    assign t_if.out_ready = out_ready;
    assign b_if.in_valid  = b_valid;
    assign b_if.datain    = b_data;
    assign b_if.out_ready = b_ready;

    fns_cac_encoder_seq #(.CODE_W(20), .IN_W(15), .BPC(1), .TIE_MSB(1'b0)) dut (
        .clock(clock), .reset(reset), .bus(m_if));
    fns_cac_encoder_seq #(.CODE_W(20), .IN_W(15), .BPC(1), .TIE_MSB(1'b1)) dut_tie (
        .clock(clock), .reset(reset), .bus(t_if));
    fns_cac_encoder_seq #(.CODE_W(20), .IN_W(15), .BPC(4), .TIE_MSB(1'b0)) dut_b4 (
        .clock(clock), .reset(reset), .bus(b_if));

    always #5 clock = ~clock;

    // Reference: Fibonacci greedy with tie-follows-upper-bit, written from the bit rules.
    function automatic logic [19:0] ref_code(input logic [14:0] d, input bit tie);
        int f [0:22];
        int r;
        bit prev;
        bit bb;
        logic [19:0] code;
        f[0] = 0; f[1] = 1; f[2] = 1;
        for (int n = 3; n <= 22; n++) f[n] = f[n-1] + f[n-2];
        r = int'(d);
        code = '0;
        prev = tie;
        if (r >= f[22]) return '0;
        for (int kk = 19; kk >= 1; kk--) begin
            if (r < f[kk+1]) bb = 1'b0;
            else if (r >= f[kk+2]) bb = 1'b1;
            else bb = prev;
            if (bb) r = r - f[kk+1];
            code = code | (20'(bb) << kk);
            prev = bb;
        end
        code = code | 20'(r);
        return code;
    endfunction

    function automatic bit ftf_bad(input logic [19:0] c);
        logic [2:0] w;
        for (int i = 0; i < 18; i++) begin
            w = c[i +: 3];
            if (w == 3'b010 || w == 3'b101) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic main_job(input logic [14:0] d, output int lat);
        @(negedge clock);
        in_valid = 1'b1; datain = d; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (m_if.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic main_release();
        @(negedge clock); out_ready = 1'b1;
        @(posedge clock); #1; out_ready = 1'b0;
    endtask

    task automatic b4_job(input logic [14:0] d, output int lat);
        @(negedge clock);
        b_valid = 1'b1; b_data = d; b_ready = 1'b0;
        @(posedge clock); #1;
        b_valid = 1'b0;
        lat = 0;
        while (b_if.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic b4_release();
        @(negedge clock); b_ready = 1'b1;
        @(posedge clock); #1; b_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (m_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", m_if.in_ready); end
        checks++; if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", m_if.out_valid); end
        checks++; if (m_if.codeout !== 20'h0) begin errors++; $display("FAIL rst_codeout got %h want 00000", m_if.codeout); end
        checks++; if (m_if.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %b want 0", m_if.out_err); end
        checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_b4_out_valid got %b want 0", b_if.out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", m_if.in_ready); end
        @(posedge clock); #1;
        checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_cycle_in_ready got %b want 1", m_if.in_ready); end
    endtask

    task automatic test_small_values();
        logic [14:0] vals [4] = '{15'd0, 15'd1, 15'd2, 15'd3};
        // 1 leaves c1 tied to c2=0, so the unit lands in c0.
        logic [19:0] exps [4] = '{20'h00000, 20'h00001, 20'h00003, 20'h00006};
        int lat;
        for (int i = 0; i < 4; i++) begin
            main_job(vals[i], lat);
            checks++; if (m_if.codeout !== exps[i]) begin errors++; $display("FAIL small_code d=%0d got %h want %h", vals[i], m_if.codeout, exps[i]); end
            checks++; if (m_if.out_err !== 1'b0) begin errors++; $display("FAIL small_err d=%0d got %b want 0", vals[i], m_if.out_err); end
            checks++; if (lat !== 19) begin errors++; $display("FAIL small_latency d=%0d got %0d want 19", vals[i], lat); end
            checks++; if (t_if.codeout !== exps[i]) begin errors++; $display("FAIL small_tie1_code d=%0d got %h want %h", vals[i], t_if.codeout, exps[i]); end
            main_release();
        end
    endtask

    task automatic test_range();
        logic [14:0] vals [3] = '{15'd17710, 15'd17711, 15'd32767};
        logic [19:0] exps [3] = '{20'hFFFFF, 20'h00000, 20'h00000};
        logic        errs [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            main_job(vals[i], lat);
            checks++; if (m_if.codeout !== exps[i]) begin errors++; $display("FAIL range_code d=%0d got %h want %h", vals[i], m_if.codeout, exps[i]); end
            checks++; if (m_if.out_err !== errs[i]) begin errors++; $display("FAIL range_err d=%0d got %b want %b", vals[i], m_if.out_err, errs[i]); end
            checks++; if (lat !== 19) begin errors++; $display("FAIL range_latency d=%0d got %0d want 19", vals[i], lat); end
            main_release();
        end
    endtask

    task automatic test_msb_tie();
        int lat;
        main_job(15'd6765, lat);
        checks++; if (m_if.codeout !== 20'h60000) begin errors++; $display("FAIL tie0_code got %h want 60000", m_if.codeout); end
        checks++; if (t_if.codeout !== 20'h80000) begin errors++; $display("FAIL tie1_code got %h want 80000", t_if.codeout); end
        checks++; if (t_if.out_err !== 1'b0) begin errors++; $display("FAIL tie1_err got %b want 0", t_if.out_err); end
        main_release();
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clock);
        in_valid = 1'b1; datain = 15'd3; out_ready = 1'b0;
        @(posedge clock); #1;
        datain = 15'd17710;
        lat = 0;
        while (m_if.out_valid !== 1'b1 && lat < 60) begin
            checks++; if (m_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_enc_in_ready cyc=%0d got %b want 0", lat, m_if.in_ready); end
            checks++; if (m_if.codeout !== 20'h60000) begin errors++; $display("FAIL bp_enc_code_hold cyc=%0d got %h want 60000", lat, m_if.codeout); end
            @(posedge clock); #1;
            lat++;
        end
        checks++; if (lat !== 19) begin errors++; $display("FAIL bp_latency1 got %0d want 19", lat); end
        checks++; if (m_if.codeout !== 20'h00006) begin errors++; $display("FAIL bp_code1 got %h want 00006", m_if.codeout); end
        for (int i = 0; i < 7; i++) begin
            @(posedge clock); #1;
            checks++; if (m_if.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", i, m_if.out_valid); end
            checks++; if (m_if.codeout !== 20'h00006) begin errors++; $display("FAIL bp_hold_code cyc=%0d got %h want 00006", i, m_if.codeout); end
            checks++; if (m_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc=%0d got %b want 0", i, m_if.in_ready); end
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", m_if.in_ready); end
        @(posedge clock); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept2_valid got %b want 0", m_if.out_valid); end
        lat = 0;
        while (m_if.out_valid !== 1'b1 && lat < 60) begin @(posedge clock); #1; lat++; end
        checks++; if (lat !== 19) begin errors++; $display("FAIL bp_latency2 got %0d want 19", lat); end
        checks++; if (m_if.codeout !== 20'hFFFFF) begin errors++; $display("FAIL bp_code2 got %h want FFFFF", m_if.codeout); end
        main_release();
        @(posedge clock); #1;
        checks++; if (m_if.codeout !== 20'hFFFFF) begin errors++; $display("FAIL idle_code_hold got %h want FFFFF", m_if.codeout); end
    endtask

    task automatic test_reset_mid_enc();
        int lat;
        @(negedge clock);
        in_valid = 1'b1; datain = 15'd17710; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checks++; if (m_if.codeout !== 20'hFFFFF) begin errors++; $display("FAIL enc_code_hold got %h want FFFFF", m_if.codeout); end
        reset = 1'b1;
        #1;
        checks++; if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", m_if.out_valid); end
        checks++; if (m_if.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", m_if.in_ready); end
        checks++; if (m_if.codeout !== 20'h0) begin errors++; $display("FAIL midrst_code got %h want 00000", m_if.codeout); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            checks++; if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output cyc=%0d got %b want 0", i, m_if.out_valid); end
        end
        main_job(15'd3, lat);
        checks++; if (m_if.codeout !== 20'h00006) begin errors++; $display("FAIL midrst_code_after got %h want 00006", m_if.codeout); end
        checks++; if (lat !== 19) begin errors++; $display("FAIL midrst_latency got %0d want 19", lat); end
        main_release();
    endtask

    task automatic test_bpc4_sweep();
        logic [14:0] vals [7] = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd17710, 15'd17711, 15'd6765};
        logic [19:0] exps [7] = '{20'h00000, 20'h00001, 20'h00003, 20'h00006, 20'hFFFFF, 20'h00000, 20'h60000};
        logic        errs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [14:0] d;
        logic [19:0] want;
        int lat;
        for (int i = 0; i < 7; i++) begin
            b4_job(vals[i], lat);
            checks++; if (b_if.codeout !== exps[i]) begin errors++; $display("FAIL b4_dir_code d=%0d got %h want %h", vals[i], b_if.codeout, exps[i]); end
            checks++; if (b_if.out_err !== errs[i]) begin errors++; $display("FAIL b4_dir_err d=%0d got %b want %b", vals[i], b_if.out_err, errs[i]); end
            checks++; if (lat !== 5) begin errors++; $display("FAIL b4_dir_latency d=%0d got %0d want 5", vals[i], lat); end
            b4_release();
        end
        for (int i = 0; i < 2000; i++) begin
            d = 15'($urandom_range(0, 19000));
            if (i % 16 == 0) d = 15'($urandom_range(0, 32767));
            want = ref_code(d, 1'b0);
            b4_job(d, lat);
            checks++; if (b_if.codeout !== want) begin errors++; $display("FAIL b4_rand_code d=%0d got %h want %h", d, b_if.codeout, want); end
            checks++; if (b_if.out_err !== (d >= 15'd17711)) begin errors++; $display("FAIL b4_rand_err d=%0d got %b want %b", d, b_if.out_err, (d >= 15'd17711)); end
            checks++; if (lat !== 5) begin errors++; $display("FAIL b4_rand_latency d=%0d got %0d want 5", d, lat); end
            checks++; if (ftf_bad(b_if.codeout) !== 1'b0) begin errors++; $display("FAIL b4_rand_ftf d=%0d code %h has 010/101, want none", d, b_if.codeout); end
            b4_release();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        b4_job(15'd17710, lat);
        checks++; if (b_if.codeout !== 20'hFFFFF) begin errors++; $display("FAIL b2b_code1 got %h want FFFFF", b_if.codeout); end
        @(negedge clock);
        b_ready = 1'b1; b_valid = 1'b1; b_data = 15'd3;
        #1;
        checks++; if (b_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", b_if.in_ready); end
        @(posedge clock); #1;
        b_ready = 1'b0; b_valid = 1'b0;
        checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", b_if.out_valid); end
        lat = 0;
        while (b_if.out_valid !== 1'b1 && lat < 60) begin @(posedge clock); #1; lat++; end
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency2 got %0d want 5", lat); end
        checks++; if (b_if.codeout !== 20'h00006) begin errors++; $display("FAIL b2b_code2 got %h want 00006", b_if.codeout); end
        b4_release();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; datain = '0; out_ready = 1'b0;
        b_valid = 1'b0; b_data = '0; b_ready = 1'b0;
        test_reset();
        test_small_values();
        test_range();
        test_msb_tie();
        test_backpressure();
        test_reset_mid_enc();
        test_bpc4_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
